imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl_pkg.sv | 19 +
 rtl/imem_fetch_ctrl_fetch_queue.sv | 53 +++++
 rtl/imem_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// rtl/imem_fetch_ctrl_pkg.sv - shared core constants and types for instruction fetch
package imem_fetch_ctrl_pkg;

    localparam int          XLEN_INST        = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_INST-1:0] pc;
        logic [XLEN_INST-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// rtl/imem_fetch_ctrl_fetch_queue.sv - sync first-word-fall-through FIFO with flush
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clock) begin
        if (!reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch controller with prefetch queue and redirect flush
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        dec_stall,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid
);

    localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);

    fetch_state_e  r_state;
    fetch_state_e  w_next_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_q_count;
    logic [CW-1:0] w_pend_count;
    logic [CW-1:0] w_out_after_resp;
    logic [CW:0]   w_total;
    logic [31:0]   w_pend_pc;
    logic [63:0]   w_q_data;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_q_empty;
    logic          w_resp;
    logic          w_resp_keep;
    logic          w_req_fire;
    logic          w_pop;

    assign w_total          = {1'b0, r_outstanding} + {1'b0, w_q_count};
    assign w_q_empty        = (w_q_count == '0);
    assign w_resp           = imem_resp_valid && (r_outstanding != '0);
    assign w_resp_keep      = w_resp && !redirect && (r_discard == '0) && (w_pend_count != '0);
    assign w_req_fire       = imem_req_valid && imem_req_ready;
    assign w_pop            = fetch_valid && !dec_stall && !redirect;
    assign w_out_after_resp = r_outstanding - {{(CW-1){1'b0}}, w_resp};
    assign w_push_entry     = '{pc: w_pend_pc, inst: imem_resp_data};
    assign w_head           = w_q_data;

    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_BOOT;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (redirect) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_BOOT: w_next_state = ST_RUN;
                ST_RUN:  if (w_total == DEPTH_W) w_next_state = ST_HOLD;
                ST_HOLD: if (w_total < DEPTH_W)  w_next_state = ST_RUN;
                default: w_next_state = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = (r_state == ST_RUN) && !redirect && (w_total < DEPTH_W);
        imem_req_addr  = r_pc;
    end

    // Responses still in flight at a redirect belong to the old path and are counted off.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect) begin
            r_pc          <= redirect_pc & ~32'h3;
            r_outstanding <= w_out_after_resp;
            r_discard     <= w_out_after_resp;
        end else begin
            if (w_req_fire) r_pc <= r_pc + 32'd4;
            r_outstanding <= w_out_after_resp + {{(CW-1){1'b0}}, w_req_fire};
            if (w_resp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
        end
    end

    fetch_queue #(.WIDTH(32), .DEPTH(QUEUE_DEPTH)) u_pend_q (
        .clock   (clock),
        .reset   (reset),
        .i_flush (redirect),
        .i_push  (w_req_fire),
        .i_data  (r_pc),
        .i_pop   (w_resp_keep),
        .o_data  (w_pend_pc),
        .o_count (w_pend_count)
    );

    fetch_queue #(.WIDTH(64), .DEPTH(QUEUE_DEPTH)) u_inst_q (
        .clock   (clock),
        .reset   (reset),
        .i_flush (redirect),
        .i_push  (w_resp_keep),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_q_data),
        .o_count (w_q_count)
    );

    assign fetch_valid       = !w_q_empty;
    assign fetch_instruction = w_q_empty ? NOP_INST : w_head.inst;
    assign fetch_pc          = w_q_empty ? r_pc     : w_head.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_stall;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic        fetch_valid;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_acc  = 0;
    int          mem_lat = 1;
    bit          mem_hold = 1'b0;
    logic [31:0] mem_q [$];
    int          due_q [$];

    imem_fetch_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .dec_stall         (dec_stall),
        .fetch_instruction (fetch_instruction),
        .fetch_pc          (fetch_pc),
        .fetch_valid       (fetch_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake, advance, then play the in-order memory.
    task automatic tick();
        bit          acc;
        logic [31:0] a;
        #1;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clock);
        #1;
        cyc++;
        if (!reset) begin
            mem_q.delete();
            due_q.delete();
            acc = 1'b0;
        end
        if (acc) begin
            mem_q.push_back(a);
            due_q.push_back(cyc + mem_lat - 1);
            n_acc++;
        end
        imem_resp_valid = 1'b0;
        if (!mem_hold && reset && mem_q.size() > 0 && due_q[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(mem_q[0]);
            void'(mem_q.pop_front());
            void'(due_q.pop_front());
        end
    endtask

    task automatic wait_valid(int lim);
        int n = 0;
        while (!fetch_valid && n < lim) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(fetch_valid), 32'd1);
    endtask

    task automatic wait_acc(int target, int lim);
        int n = 0;
        while (n_acc < target && n < lim) begin
            tick();
            n++;
        end
        imem_req_ready = 1'b0;
        check("acc_count", 32'(n_acc), 32'(target));
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_req_valid"},   32'(imem_req_valid), 32'd0);
        check({tag, "_fetch_valid"}, 32'(fetch_valid),    32'd0);
        check({tag, "_inst"},        fetch_instruction,   32'h0000_0013);
        check({tag, "_pc"},          fetch_pc,            32'h0000_0000);
    endtask

    initial begin
        reset = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect = 1'b0; redirect_pc = '0; dec_stall = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");

        // Straight-line fetch with a 1-cycle memory
        reset = 1'b1;
        tick();
        check("boot_req_valid", 32'(imem_req_valid), 32'd1);
        check("boot_req_addr",  imem_req_addr, 32'h0);
        tick();
        check("lat_not_yet", 32'(fetch_valid), 32'd0);
        check("req_addr_4",  imem_req_addr, 32'h4);
        tick();
        check("lat_valid",   32'(fetch_valid), 32'd1);
        check("seq_pc0",     fetch_pc, 32'h0);
        check("seq_inst0",   fetch_instruction, inst_of(32'h0));
        tick();
        check("seq_pc4",     fetch_pc, 32'h4);
        tick();
        check("seq_pc8",     fetch_pc, 32'h8);
        check("seq_inst8",   fetch_instruction, inst_of(32'h8));

        // Redirect coinciding with a response and a pop
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        check("rd_same_no_req", 32'(imem_req_valid), 32'd0);
        check("rd_same_pop",    32'(fetch_valid), 32'd1);
        tick();
        redirect = 1'b0;
        check("rd_same_empty",  32'(fetch_valid), 32'd0);
        check("rd_same_pc",     fetch_pc, 32'h200);
        wait_valid(20);
        check("rd_same_first",  fetch_pc, 32'h200);
        check("rd_same_inst",   fetch_instruction, inst_of(32'h200));

        // Address wrap at the top of the 32-bit space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check("wrap_req_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_req_zero", imem_req_addr, 32'h0);
        wait_valid(20);
        check("wrap_fetch_top", fetch_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_fetch_zero", fetch_pc, 32'h0);

        // Redirect with two requests outstanding
        reset = 1'b0; tick(); tick();
        reset = 1'b1; mem_hold = 1'b1; imem_req_ready = 1'b1; n_acc = 0;
        wait_acc(2, 20);
        redirect = 1'b1; redirect_pc = 32'h0000_0101;
        #1;
        check("rd_out_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect = 1'b0;
        check("rd_out_addr", imem_req_addr, 32'h100);
        mem_hold = 1'b0; imem_req_ready = 1'b1;
        wait_valid(20);
        check("rd_out_first_pc", fetch_pc, 32'h100);
        check("rd_out_inst",     fetch_instruction, inst_of(32'h100));

        // Decode stall fills the queue, then drains in order
        reset = 1'b0; tick(); tick();
        dec_stall = 1'b1; n_acc = 0; reset = 1'b1;
        repeat (10) tick();
        check("stall_acc",       32'(n_acc), 32'd4);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        check("stall_valid",     32'(fetch_valid), 32'd1);
        dec_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_pc%0d", i),   fetch_pc, 32'(4 * i));
            check($sformatf("drain_inst%0d", i), fetch_instruction, inst_of(32'(4 * i)));
            tick();
        end

        // Reset mid-stream with three requests in flight
        reset = 1'b0; tick();
        reset = 1'b1; mem_hold = 1'b1; imem_req_ready = 1'b1; n_acc = 0;
        wait_acc(3, 20);
        reset = 1'b0;
        tick();
        check_reset_outputs("mid_rst");
        mem_hold = 1'b0; imem_req_ready = 1'b1; reset = 1'b1;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        tick();
        check("post_rst_stray",     32'(fetch_valid), 32'd0);
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_rst_req_addr",  imem_req_addr, 32'h0);
        wait_valid(20);
        check("post_rst_fetch_pc",  fetch_pc, 32'h0);
        check("post_rst_inst",      fetch_instruction, inst_of(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
